top_level_p_sense: RTL and testbench

- Avalon-MM slave parallel input port, the read-side counterpart of the 8-bit output PIO.
- Samples an 8-bit external input bus (sensor/button lines) through a synchronizer and detects rising edges into a sticky edge-capture register.
- Raises a level interrupt to the Nios II CPU when any unmasked captured bit is set.
- The CPU reads the data, mask and capture registers and clears capture bits over the same 2-bit-address Avalon slave interface used by the output PIOs.

---
 rtl/top_level_p_sense.sv | 153 +++++++++++++++
 tb/tb_top_level_p_sense.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/top_level_p_sense.sv
// Purpose : Avalon-MM slave input PIO; synchronises in_port, captures rising
//           edges into sticky write-1-to-clear bits, raises a maskable level irq.
// Latency : readdata is registered (1 clk after address). An in_port rise
//           reaches edge_capture SYNC_STAGES clks after it is sampled, and irq
//           follows one clk later.
// Backpressure: none. clk_en is tied active and there are no wait states.
//
// Ports:
//   clk        system clock, single domain
//   reset_n    asynchronous active-low reset
//   address    register select: 0 data, 1 direction (reads 0), 2 irq_mask,
//              3 edge_capture
//   chipselect slave select, qualifies write_n
//   write_n    active-low write strobe
//   writedata  write data, bits [DATA_WIDTH-1:0] used
//   in_port    asynchronous external inputs
//   readdata   registered read data, zero-extended
//   irq        level interrupt, high while any unmasked capture bit is set

module top_level_p_sense #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_DIR     = 2'd1;
  localparam logic [1:0] ADDR_MASK    = 2'd2;
  localparam logic [1:0] ADDR_CAPTURE = 2'd3;

  // Synchronizer chain; stage 0 is the metastability-exposed flop.
  logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] d_sync;
  logic [DATA_WIDTH-1:0] d_prev;
  logic [DATA_WIDTH-1:0] rise;

  logic [DATA_WIDTH-1:0] irq_mask;
  logic [DATA_WIDTH-1:0] edge_capture;
  logic [DATA_WIDTH-1:0] capture_next;
  logic [DATA_WIDTH-1:0] clear_bits;

  logic                  wr_en;
  logic                  wr_mask;
  logic                  wr_capture;
  logic [31:0]           rd_mux;

  // Upper writedata bits are unused when DATA_WIDTH < 32.
  logic                  unused_writedata;
  assign unused_writedata = ^writedata;

  // ---------------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign d_sync = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Rising-edge detect. d_prev resets to 0, so a line already high when reset
  // is released produces exactly one rise once it reaches d_sync.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_prev <= '0;
    end else begin
      d_prev <= d_sync;
    end
  end

  assign rise = d_sync & ~d_prev;

  // ---------------------------------------------------------------------------
  // Slave write decode. Writes to data and direction addresses fall through.
  // ---------------------------------------------------------------------------
  assign wr_en      = chipselect & ~write_n;
  assign wr_mask    = wr_en & (address == ADDR_MASK);
  assign wr_capture = wr_en & (address == ADDR_CAPTURE);
  assign clear_bits = wr_capture ? writedata[DATA_WIDTH-1:0] : '0;

  // Clear is applied before the set so a rise in the same cycle as its
  // clear still lands in the register and no edge is lost.
  assign capture_next = (edge_capture & ~clear_bits) | rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
    end else begin
      edge_capture <= capture_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
    end else if (wr_mask) begin
      irq_mask <= writedata[DATA_WIDTH-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Read path. Registered every cycle regardless of chipselect; reads of the
  // capture register see the value before any same-cycle clear.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux[DATA_WIDTH-1:0] = d_sync;
      ADDR_DIR:     rd_mux = '0;
      ADDR_MASK:    rd_mux[DATA_WIDTH-1:0] = irq_mask;
      ADDR_CAPTURE: rd_mux[DATA_WIDTH-1:0] = edge_capture;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

  // irq is evaluated on the current register values, so it trails a capture
  // set or a mask write by one clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |(edge_capture & irq_mask);
    end
  end

endmodule

// File: tb/tb_top_level_p_sense.sv
// Directed bench for top_level_p_sense: register reads, edge capture timing,
// write-1-to-clear, set-wins collision, masking and asynchronous reset.
module tb_top_level_p_sense;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int total;
  int bad;

  top_level_p_sense #(
    .DATA_WIDTH  (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One-cycle slave write; address is left on the bus afterwards.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [1:0] a);
    address = a;
    tick();
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 8'h00;

    // ---- 1: reset state and register reads --------------------------------
    tick();
    tick();
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_rdata", readdata, 32'd0);
    reset_n = 1'b1;
    tick();
    bus_read(2'd0); check("rd_a0_reset", readdata, 32'd0);
    bus_read(2'd1); check("rd_a1_reset", readdata, 32'd0);
    bus_read(2'd2); check("rd_a2_reset", readdata, 32'd0);
    bus_read(2'd3); check("rd_a3_reset", readdata, 32'd0);
    check("irq_after_reads", {31'd0, irq}, 32'd0);
    // Writes to data/direction addresses have no effect.
    bus_write(2'd1, 32'hFF);
    bus_read(2'd1); check("dir_write_ignored", readdata, 32'd0);
    bus_write(2'd0, 32'hFF);
    bus_read(2'd0); check("data_write_ignored", readdata, 32'd0);

    // ---- 2: mask=05, rise on bit 0 ----------------------------------------
    bus_write(2'd2, 32'h05);
    bus_read(2'd2); check("mask_readback", readdata, 32'h05);
    address = 2'd3;
    in_port = 8'h01;
    tick(); // edge N: stage 0 samples
    check("n0_irq", {31'd0, irq}, 32'd0);
    tick(); // N+1: d_sync high
    check("n1_cap", readdata, 32'd0);
    tick(); // N+2: capture sets, readdata still shows old value
    check("n2_cap_pre", readdata, 32'd0);
    check("n2_irq", {31'd0, irq}, 32'd0);
    tick(); // N+3
    check("n3_cap", readdata, 32'h01);
    check("n3_irq", {31'd0, irq}, 32'd1);
    bus_read(2'd0); check("rd_data_01", readdata, 32'h01);

    // ---- 3: write-1-to-clear ----------------------------------------------
    bus_write(2'd3, 32'h00);
    bus_read(2'd3); check("clr0_keeps", readdata, 32'h01);
    check("clr0_irq", {31'd0, irq}, 32'd1);
    bus_write(2'd3, 32'h01);
    check("clr_preclear_read", readdata, 32'h01);
    check("clr_irq_lag", {31'd0, irq}, 32'd1);
    tick();
    check("clr_cap", readdata, 32'd0);
    check("clr_irq_fall", {31'd0, irq}, 32'd0);

    // ---- 4: set wins over same-cycle clear --------------------------------
    in_port = 8'h03;
    tick(); // N
    tick(); // N+1
    bus_write(2'd3, 32'h02); // lands on N+2, same edge as the set
    tick();
    check("set_wins", readdata, 32'h02);
    check("set_wins_irq_masked", {31'd0, irq}, 32'd0);
    bus_write(2'd3, 32'h02);
    tick();
    check("bit1_cleared", readdata, 32'd0);

    // ---- 5: masked capture, then unmask -----------------------------------
    bus_write(2'd2, 32'h00);
    in_port = 8'h83;
    tick();
    tick();
    tick();
    bus_read(2'd3); check("cap_80", readdata, 32'h80);
    check("masked_irq", {31'd0, irq}, 32'd0);
    bus_write(2'd2, 32'h80);
    check("unmask_irq_1clk", {31'd0, irq}, 32'd0);
    tick();
    check("unmask_irq_2clk", {31'd0, irq}, 32'd1);

    // ---- 6: async reset mid-operation -------------------------------------
    in_port = 8'h00;
    tick();
    tick();
    tick();
    in_port = 8'hFF;
    tick();
    tick();
    tick();
    bus_write(2'd2, 32'hFF);
    address = 2'd3;
    tick();
    tick();
    check("cap_ff", readdata, 32'hFF);
    check("irq_ff", {31'd0, irq}, 32'd1);
    #2;
    reset_n = 1'b0;
    in_port = 8'h10;
    #1;
    check("async_irq", {31'd0, irq}, 32'd0);
    check("async_rdata", readdata, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("post_rst_one_bit", readdata, 32'h10);
    check("post_rst_irq", {31'd0, irq}, 32'd0);
    bus_write(2'd3, 32'h10);
    tick();
    tick();
    tick();
    check("no_repeat_edge", readdata, 32'd0);
    bus_read(2'd2); check("mask_reset", readdata, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
